// File: rtl/sram_reg_read_responder.sv
// sram_reg_read_responder
//
// Memory-side responder for host register reads of the SRAM process table.
// Read addresses from the register-read arbiter are queued in a small FIFO.
// Each address is issued to the SRAM burst read port when the sketch update
// path does not own that port. The two returned beats are forwarded to the
// register path as a pair. Status counters feed ro_regs.
//
// Optional feature macro: RSP_TIMEOUT_EN
//   defined   : per-beat response timer, TO1 state, stale-beat drain and
//               timeout_count are built in.
//   undefined : the block waits indefinitely for beats; timeout_count reads 0.
//
// Ports
//   axi_aclk, axi_aresetn      clock, asynchronous active-low reset
//   req_addr, req_valid        read request strobe from the register path
//   req_full                   request FIFO full
//   mem_rd_addr, mem_rd_req    SRAM burst read request (address held stable)
//   mem_rd_ready, upd_busy     SRAM port ready / port owned by sketch update
//   mem_rd_data(_valid)        SRAM read beats
//   rsp_data, rsp_valid        registered response beats
//   rd_count                   completed requests, wraps
//   drop_count                 requests lost to a full FIFO, saturates
//   timeout_count              requests completed by timeout, saturates
//
// Handshake: a read request is taken at a rising edge where mem_rd_req=1,
// mem_rd_ready=1 and upd_busy=0; mem_rd_req and mem_rd_addr stay constant
// until then. req_valid is a one-cycle strobe with no back-pressure; a strobe
// that finds the FIFO full (and no pop in that cycle) is dropped and counted.

module sram_reg_read_responder #(
    parameter int ADDR_WIDTH      = 19,
    parameter int DATA_WIDTH      = 201,
    parameter int FIFO_DEPTH_BITS = 2,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_valid,
    output logic                  req_full,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    output logic                  mem_rd_req,
    input  logic                  mem_rd_ready,
    input  logic                  upd_busy,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  mem_rd_data_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_valid,
    output logic [31:0]           rd_count,
    output logic [15:0]           drop_count,
    output logic [15:0]           timeout_count
);

    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam logic [FIFO_DEPTH_BITS:0] PTR_ONE = 1;

    // A timeout of zero cycles would make every wait expire immediately.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_cycles_invalid
    end

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT0,
        WAIT1,
        TO1
    } state_t;

    state_t state, state_d;

    // ---------------- request FIFO ----------------
    logic [ADDR_WIDTH-1:0]    fifo_mem [DEPTH];
    logic [FIFO_DEPTH_BITS:0] wr_ptr, rd_ptr;
    logic                     fifo_empty, fifo_full, push, pop, drop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_DEPTH_BITS] != rd_ptr[FIFO_DEPTH_BITS]) &&
                        (wr_ptr[FIFO_DEPTH_BITS-1:0] == rd_ptr[FIFO_DEPTH_BITS-1:0]);
    assign pop        = (state == IDLE) && !fifo_empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign push       = req_valid && (!fifo_full || pop);
    assign drop       = req_valid && fifo_full && !pop;
    assign req_full   = fifo_full;
    assign mem_rd_req = (state == ISSUE);

    always_ff @(posedge axi_aclk) begin
        if (push) begin
            fifo_mem[wr_ptr[FIFO_DEPTH_BITS-1:0]] <= req_addr;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            mem_rd_addr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) begin
                rd_ptr      <= rd_ptr + PTR_ONE;
                mem_rd_addr <= fifo_mem[rd_ptr[FIFO_DEPTH_BITS-1:0]];
            end
        end
    end

    // ---------------- response FSM ----------------
    logic                  rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_d;
    logic                  rd_inc;
    logic                  beat_ok;

`ifdef RSP_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_ONE = 1;

    logic [TW-1:0] timer, timer_d;
    logic [1:0]    stale, stale_d;
    logic          expired, stale_hit, to_inc;

    // Beats left over from timed-out requests are consumed before any
    // beat counts towards the current request.
    assign stale_hit = mem_rd_data_valid && (stale != 2'd0);
    assign beat_ok   = mem_rd_data_valid && (stale == 2'd0);
    assign expired   = (timer == TIMER_MAX);
`else
    assign beat_ok   = mem_rd_data_valid;
`endif

    always_comb begin
        state_d     = state;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data;
        rd_inc      = 1'b0;
`ifdef RSP_TIMEOUT_EN
        timer_d     = timer;
        stale_d     = stale - (stale_hit ? 2'd1 : 2'd0);
        to_inc      = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!fifo_empty) state_d = ISSUE;
            end
            ISSUE: begin
                if (mem_rd_ready && !upd_busy) begin
                    state_d = WAIT0;
`ifdef RSP_TIMEOUT_EN
                    timer_d = '0;
`endif
                end
            end
            WAIT0: begin
                // A beat in the expiry cycle takes priority over the timer.
                if (beat_ok) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = mem_rd_data;
                    state_d     = WAIT1;
`ifdef RSP_TIMEOUT_EN
                    timer_d     = '0;
                end else if (expired) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '1;
                    state_d     = TO1;
                    stale_d     = 2'd2;
                    rd_inc      = 1'b1;
                    to_inc      = 1'b1;
                end else begin
                    timer_d     = timer + TIMER_ONE;
`endif
                end
            end
            WAIT1: begin
                if (beat_ok) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = mem_rd_data;
                    rd_inc      = 1'b1;
                    state_d     = IDLE;
`ifdef RSP_TIMEOUT_EN
                end else if (expired) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '1;
                    stale_d     = 2'd1;
                    rd_inc      = 1'b1;
                    to_inc      = 1'b1;
                    state_d     = IDLE;
                end else begin
                    timer_d     = timer + TIMER_ONE;
`endif
                end
            end
            TO1: begin
`ifdef RSP_TIMEOUT_EN
                rsp_valid_d = 1'b1;
                rsp_data_d  = '1;
`endif
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state      <= IDLE;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rd_count   <= '0;
            drop_count <= '0;
        end else begin
            state     <= state_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            if (rd_inc) rd_count <= rd_count + 32'd1;
            if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
        end
    end

`ifdef RSP_TIMEOUT_EN
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            timer         <= '0;
            stale         <= '0;
            timeout_count <= '0;
        end else begin
            timer <= timer_d;
            stale <= stale_d;
            if (to_inc && (timeout_count != 16'hFFFF)) timeout_count <= timeout_count + 16'd1;
        end
    end
`else
    assign timeout_count = '0;
`endif

endmodule

// File: tb/tb_sram_reg_read_responder.sv
module tb_sram_reg_read_responder;

  localparam int AW = 19;
  localparam int DW = 201;
`ifdef RSP_TIMEOUT_EN
  localparam int TO_CYC = 8;
`else
  localparam int TO_CYC = 255;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] req_addr = '0;
  logic          req_valid = 1'b0;
  logic          req_full;
  logic [AW-1:0] mem_rd_addr;
  logic          mem_rd_req;
  logic          mem_rd_ready = 1'b0;
  logic          upd_busy = 1'b0;
  logic [DW-1:0] mem_rd_data = '0;
  logic          mem_rd_data_valid = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          rsp_valid;
  logic [31:0]   rd_count;
  logic [15:0]   drop_count;
  logic [15:0]   timeout_count;

  sram_reg_read_responder #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .FIFO_DEPTH_BITS(2),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .axi_aclk(clk),
    .axi_aresetn(rst_n),
    .req_addr(req_addr),
    .req_valid(req_valid),
    .req_full(req_full),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_req(mem_rd_req),
    .mem_rd_ready(mem_rd_ready),
    .upd_busy(upd_busy),
    .mem_rd_data(mem_rd_data),
    .mem_rd_data_valid(mem_rd_data_valid),
    .rsp_data(rsp_data),
    .rsp_valid(rsp_valid),
    .rd_count(rd_count),
    .drop_count(drop_count),
    .timeout_count(timeout_count)
  );

  // ---------------- reference model state ----------------
  logic [DW-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  int exp_rd = 0;
  int exp_drop = 0;
  int exp_to = 0;

  // SRAM contents: each address returns a fixed pair of beats.
  function automatic logic [DW-1:0] beat_val(input logic [AW-1:0] a, input int b);
    logic [208:0] t;
    if (b == 0) t = {11{a ^ 19'h2A5C3}};
    else        t = {11{a ^ 19'h15A3C}} << 7;
    return t[DW-1:0];
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rsp_unexpected: got %0h expected no beat", rsp_data);
      end else begin
        chk("rsp_data", rsp_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic [AW-1:0] a);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d);
    @(negedge clk);
    mem_rd_data       = d;
    mem_rd_data_valid = 1'b1;
    @(negedge clk);
    mem_rd_data_valid = 1'b0;
    mem_rd_data       = {7{32'($urandom)}};
  endtask

  // mode 0: two beats; mode 1: no beats (WAIT0 timeout); mode 2: beat 0 only
  task automatic serve(input logic [AW-1:0] a, input int busy, input int mode,
                       input int gap, output int first_c);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    first_c = -1;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      if (mem_rd_req) begin
        if (first_c < 0) first_c = c;
        chk("mem_rd_addr", DW'(mem_rd_addr), DW'(a));
        if (n >= busy) begin
          upd_busy     = 1'b0;
          mem_rd_ready = 1'b1;
          got          = 1'b1;
        end else begin
          upd_busy     = 1'b1;
          mem_rd_ready = 1'($urandom_range(0, 1));
          n++;
        end
      end
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL handshake_timeout: no mem_rd_req for addr %0h within 400 cycles", a);
      return;
    end
    @(negedge clk);
    mem_rd_ready = 1'b0;
    upd_busy     = 1'($urandom_range(0, 1));
    chk("mem_rd_req_after_hs", DW'(mem_rd_req), DW'(0));
    repeat ($urandom_range(0, 3)) @(negedge clk);
    if (mode != 1) send_beat(beat_val(a, 0));
    if (mode == 0) begin
      repeat (gap) @(negedge clk);
      send_beat(beat_val(a, 1));
    end else begin
      repeat (TO_CYC + 4) @(negedge clk);
      // late beats arriving after the timeout must be swallowed
      for (int k = 0; k < ((mode == 1) ? 2 : 1); k++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_beat({7{32'($urandom)}});
      end
    end
    repeat (3) @(negedge clk);
    upd_busy = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int busy, input int mode, input int gap);
    int first_c;
    case (mode)
      0: begin exp_q.push_back(beat_val(a, 0)); exp_q.push_back(beat_val(a, 1)); end
      1: begin exp_q.push_back('1); exp_q.push_back('1); end
      default: begin exp_q.push_back(beat_val(a, 0)); exp_q.push_back('1); end
    endcase
    exp_rd++;
    if (mode != 0) exp_to++;
    send_req(a);
    chk("req_latency_early", DW'(mem_rd_req), DW'(0));
    serve(a, busy, mode, gap, first_c);
    chk("req_latency", DW'(first_c), DW'(0));
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_rd_count"}, DW'(rd_count), DW'(exp_rd));
    chk({tag, "_drop_count"}, DW'(drop_count), DW'(exp_drop));
    chk({tag, "_timeout_count"}, DW'(timeout_count), DW'(exp_to));
    chk({tag, "_req_full"}, DW'(req_full), DW'(0));
    chk({tag, "_mem_rd_req"}, DW'(mem_rd_req), DW'(0));
    chk({tag, "_rsp_valid"}, DW'(rsp_valid), DW'(0));
  endtask

  task automatic check_zero(input string tag);
    check_counters(tag);
    chk({tag, "_rsp_data"}, rsp_data, DW'(0));
    chk({tag, "_mem_rd_addr"}, DW'(mem_rd_addr), DW'(0));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [AW-1:0] ov[6];
    logic [AW-1:0] a;
    int fc;

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single read, back-to-back beats
    do_read(19'h1234, 0, 0, 0);
    check_counters("single");

    // update contention for 10 cycles
    do_read(AW'($urandom), 10, 0, 0);

    // randomized reads with contention and beat gaps
    for (int i = 0; i < 12; i++) begin
      do_read(AW'($urandom), $urandom_range(0, 4), 0, $urandom_range(0, 2));
    end
    check_counters("random");

    // FIFO overflow: SRAM not ready, six back-to-back strobes
    mem_rd_ready = 1'b0;
    for (int k = 0; k < 6; k++) ov[k] = AW'($urandom);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 5) chk("req_full_at_excess", DW'(req_full), DW'(1));
      req_valid = 1'b1;
      req_addr  = ov[k];
    end
    @(negedge clk);
    req_valid = 1'b0;
    exp_drop = 1;
    chk("overflow_drop_count", DW'(drop_count), DW'(exp_drop));
    chk("overflow_req_full", DW'(req_full), DW'(1));
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(beat_val(ov[k], 0));
      exp_q.push_back(beat_val(ov[k], 1));
      exp_rd++;
    end
    for (int k = 0; k < 5; k++) serve(ov[k], $urandom_range(0, 2), 0, $urandom_range(0, 1), fc);
    check_counters("overflow");

`ifdef RSP_TIMEOUT_EN
    do_read(AW'($urandom), 0, 1, 0);
    check_counters("timeout0");
    do_read(AW'($urandom), 0, 0, 0);
    do_read(AW'($urandom), 1, 2, 0);
    do_read(AW'($urandom), 0, 0, 1);
    check_counters("timeout1");
`endif

    // reset in WAIT1 after beat 0
    a = AW'($urandom);
    exp_q.push_back(beat_val(a, 0));
    send_req(a);
    fc = 0;
    while (!mem_rd_req && fc < 50) begin
      @(negedge clk);
      fc++;
    end
    chk("rst_test_req_seen", DW'(mem_rd_req), DW'(1));
    mem_rd_ready = 1'b1;
    @(negedge clk);
    mem_rd_ready = 1'b0;
    @(negedge clk);
    mem_rd_data       = beat_val(a, 0);
    mem_rd_data_valid = 1'b1;
    @(negedge clk);
    mem_rd_data_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    exp_rd = 0;
    exp_drop = 0;
    exp_to = 0;
    check_zero("mid_reset");
    rst_n = 1'b1;
    // the orphaned beat 1 must not be forwarded
    send_beat(beat_val(a, 1));
    repeat (2) @(negedge clk);
    check_counters("post_reset");
    do_read(AW'($urandom), 0, 0, 0);
    check_counters("final");

    repeat (5) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL rsp_missing: got %0d beats outstanding expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
